src_frame_loader: RTL

//  Parametrised GPIO frame loader: Raspberry Pi pushes one multi-channel frame word-by-word over GPIO strobes into
//  on-chip ping-pong RAM banks; the CNN datapath reads the completed bank while the next frame loads.

---
 rtl/src_loader_pkg.sv | 22 ++
 rtl/src_bank_ram.sv | 29 ++
 rtl/src_frame_loader.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/src_loader_pkg.sv
// Shared types and helpers for the ping-pong GPIO frame loader.
package src_loader_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } state_t;

  typedef logic bank_t;

  // Address width that stays legal for a single-entry dimension.
  function automatic int addr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Linear RAM address of {bank, ch, pix}, packed densely so no words are wasted.
  function automatic int pack_addr(input int bank, input int ch, input int pix,
                                   input int channels, input int pix_depth);
    return (bank * channels + ch) * pix_depth + pix;
  endfunction

endpackage

// File: rtl/src_bank_ram.sv
// Simple dual-port RAM holding both frame banks: one write port, one registered read port.
module src_bank_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 1568,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: the array itself is never reset; clearing it would force it out of block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/src_frame_loader.sv
// GPIO frame loader: RPi strobes one frame into a free bank while the CNN reads the other.
// Optional abort on strobe inactivity: define SRC_LOADER_TIMEOUT_EN.
module src_frame_loader
  import src_loader_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int PIX_DEPTH   = 784,
  parameter int CHANNELS    = 1,
  parameter int TIMEOUT_CYC = 65535,
  localparam int PIX_AW     = addr_width(PIX_DEPTH),
  localparam int CH_W       = addr_width(CHANNELS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              igo,
  input  logic              rpi_en,
  input  logic              rpi_wen,
  input  logic [DATA_W-1:0] io,
  output logic              rpi_start,
  output logic              busy,
  output logic              ready,
  output logic              rd_bank,
  input  logic              rd_done,
  output logic              err,
  input  logic              cena,
  input  logic [CH_W-1:0]   ach,
  input  logic [PIX_AW-1:0] aa,
  output logic [DATA_W-1:0] qa
);

  localparam int WORDS  = 2 * CHANNELS * PIX_DEPTH;
  localparam int MEM_AW = $clog2(WORDS);
  localparam logic [CH_W-1:0]   LAST_CH  = CH_W'(CHANNELS - 1);
  localparam logic [PIX_AW-1:0] LAST_PIX = PIX_AW'(PIX_DEPTH - 1);

  logic [1:0]             igo_sy, en_sy, wen_sy;
  logic [1:0][DATA_W-1:0] io_sy;
  logic                   igo_prev, en_prev, igo_edge, en_edge;

  always_ff @(posedge clk) begin
    if (rst) begin
      igo_sy   <= '0;
      en_sy    <= '0;
      wen_sy   <= '0;
      io_sy    <= '0;
      igo_prev <= 1'b0;
      en_prev  <= 1'b0;
      igo_edge <= 1'b0;
      en_edge  <= 1'b0;
    end else begin
      igo_sy   <= {igo_sy[0], igo};
      en_sy    <= {en_sy[0], rpi_en};
      wen_sy   <= {wen_sy[0], rpi_wen};
      io_sy    <= {io_sy[0], io};
      igo_prev <= igo_sy[1];
      en_prev  <= en_sy[1];
      igo_edge <= igo_sy[1] & ~igo_prev;
      en_edge  <= en_sy[1] & ~en_prev;
    end
  end

  state_t              state;
  bank_t               wr_bank;
  logic [CH_W-1:0]     ch;
  logic [PIX_AW-1:0]   pix;
  logic [1:0]          full, avail, full_next;
  logic                rd_valid, last_word, frame_done, release_rd, tmo_hit;
  logic                we;
  logic [MEM_AW-1:0]   waddr, raddr;
  logic [DATA_W-1:0]   wdata;

  assign busy       = rpi_start;
  assign last_word  = (ch == LAST_CH) && (pix == LAST_PIX);
  assign frame_done = (state == LOAD) && en_edge && last_word;
  assign release_rd = rd_done && rd_valid;

  // Handoff only looks at banks full before this cycle, so a frame finishing
  // alongside rd_done is exposed one cycle later with a single ready.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    avail = full;
    if (release_rd) avail[rd_bank] = 1'b0;
    full_next = avail;
    if (frame_done) full_next[wr_bank] = 1'b1;
  end

  // NOTE: state registers use <= so every branch sees last cycle's values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rpi_start <= 1'b0;
      err       <= 1'b0;
      ready     <= 1'b0;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      rd_valid  <= 1'b0;
      full      <= '0;
      ch        <= '0;
      pix       <= '0;
      we        <= 1'b0;
      waddr     <= '0;
      wdata     <= '0;
    end else begin
      err   <= 1'b0;
      ready <= 1'b0;
      we    <= 1'b0;
      case (state)
        IDLE: begin
          if (igo_edge) begin
            if (!(&full)) begin
              state     <= LOAD;
              wr_bank   <= full[0];  // lower free bank
              ch        <= '0;
              pix       <= '0;
              rpi_start <= 1'b1;
            end else begin
              err <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (en_edge) begin
            we    <= 1'b1;
            waddr <= MEM_AW'(pack_addr(int'(wr_bank), int'(ch), int'(pix), CHANNELS, PIX_DEPTH));
            wdata <= wen_sy[1] ? io_sy[1] : '0;
            if (last_word) begin
              state     <= IDLE;
              rpi_start <= 1'b0;
            end else if (pix == LAST_PIX) begin
              pix <= '0;
              ch  <= ch + 1'b1;
            end else begin
              pix <= pix + 1'b1;
            end
          end else if (tmo_hit) begin
            state     <= IDLE;
            rpi_start <= 1'b0;
            err       <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      full <= full_next;
      if (!rd_valid || release_rd) begin
        if (|avail) begin
          rd_valid <= 1'b1;
          rd_bank  <= ~avail[0];
          ready    <= 1'b1;
        end else begin
          rd_valid <= 1'b0;
        end
      end
    end
  end

`ifdef SRC_LOADER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_cnt;

  always_ff @(posedge clk) begin
    if (rst || state != LOAD || en_edge) tmo_cnt <= '0;
    else                                 tmo_cnt <= tmo_cnt + 1'b1;
  end

  assign tmo_hit = (state == LOAD) && !en_edge && (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
`else
  // Keeps the parameter referenced when the timeout is compiled out.
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYC != 0);
  assign tmo_hit        = 1'b0;
`endif

  assign raddr = MEM_AW'(pack_addr(int'(rd_bank), int'(ach), int'(aa), CHANNELS, PIX_DEPTH));

  src_bank_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (WORDS),
    .AW     (MEM_AW)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .re    (~cena),
    .raddr (raddr),
    .rdata (qa)
  );

endmodule
